// File: rtl/sid_write_sequencer.sv
// Timed register-write sequencer: queues {delay, addr, data} commands and replays them onto the
// sid8580 register port, counting delays in ce_1m ticks. Readback commands: define SID_SEQ_READBACK_EN.
module sid_write_sequencer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DLY_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce_1m,
    input  logic                   flush,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [DLY_W-1:0]       cmd_delay,
    input  logic [4:0]             cmd_addr,
    input  logic [7:0]             cmd_data,
    input  logic                   cmd_read,
    output logic                   sid_we,
    output logic [4:0]             sid_addr,
    output logic [7:0]             sid_data,
    input  logic [7:0]             sid_data_out,
    output logic                   rd_valid,
    output logic [7:0]             rd_data,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef struct packed {
        logic [DLY_W-1:0] delay;
        logic [4:0]       addr;
        logic [7:0]       data;
`ifdef SID_SEQ_READBACK_EN
        logic             rd;
`endif
    } entry_t;

`ifdef SID_SEQ_READBACK_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_READ_CAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;
`endif

    state_t           state_q, state_d;
    entry_t           mem [DEPTH];
    entry_t           wr_entry;
    entry_t           head;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    count;
    logic [DLY_W-1:0] cnt_q;
    logic [4:0]       addr_q;
    logic [7:0]       data_q;
    logic             rd_q;
    logic             we_q;
    logic             fifo_empty;
    logic             push, pop, issue, issue_wr, cnt_dec;
`ifdef SID_SEQ_READBACK_EN
    logic             cap;
`endif

    assign fifo_empty = (count == '0);
    assign cmd_ready  = (count != LW'(DEPTH));
    assign push       = cmd_valid && cmd_ready && !flush;
    assign head       = mem[rd_ptr];
    assign fifo_level = count;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign issue_wr   = issue && !rd_q;
    // Registered strobe, additionally masked so no write can escape during reset or flush.
    assign sid_we     = we_q && !reset && !flush;

    always_comb begin
        wr_entry.delay = cmd_delay;
        wr_entry.addr  = cmd_addr;
        wr_entry.data  = cmd_data;
`ifdef SID_SEQ_READBACK_EN
        wr_entry.rd    = cmd_read;
`endif
    end

    // Command storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes; flush overrides everything.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        issue   = 1'b0;
        cnt_dec = 1'b0;
`ifdef SID_SEQ_READBACK_EN
        cap     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ce_1m) begin
                    if (cnt_q == '0) begin
                        issue   = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
`ifdef SID_SEQ_READBACK_EN
                if (rd_q) begin
                    cap     = 1'b1;
                    state_d = S_READ_CAP;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
`ifdef SID_SEQ_READBACK_EN
            S_READ_CAP: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            pop     = 1'b0;
            issue   = 1'b0;
            cnt_dec = 1'b0;
`ifdef SID_SEQ_READBACK_EN
            cap     = 1'b0;
`endif
        end
    end

    // FIFO pointers/level, working registers and the bus-side output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            sid_addr <= '0;
            sid_data <= '0;
        end else begin
            we_q <= issue_wr;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + LW'(push) - LW'(pop);
            end
            if (pop) begin
                cnt_q  <= head.delay;
                addr_q <= head.addr;
                data_q <= head.data;
            end else if (cnt_dec) begin
                cnt_q <= cnt_q - DLY_W'(1);
            end
            if (issue) begin
                sid_addr <= addr_q;
                if (issue_wr) begin
                    sid_data <= data_q;
                end
            end
        end
    end

`ifdef SID_SEQ_READBACK_EN
    // Read path: address goes out in ISSUE, data is captured one clock later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (pop) begin
                rd_q <= head.rd;
            end
            rd_valid <= cap;
            if (cap) begin
                rd_data <= sid_data_out;
            end
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{cmd_read, sid_data_out};
    assign rd_q          = 1'b0;
    assign rd_valid      = 1'b0;
    assign rd_data       = '0;
`endif

endmodule

// File: tb/tb_sid_write_sequencer.sv
// Self-checking bench for sid_write_sequencer: directed steps plus randomized streams checked
// against a tick-level timing model (issue tick = max(prev issue, push tick) + delay + 1).
module tb_sid_write_sequencer;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned DLY_W = 16;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam int          CE_P  = 8;
    localparam int          LIMIT = 6000;

    logic             clk = 1'b0;
    logic             reset;
    logic             ce_1m = 1'b0;
    logic             flush;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [DLY_W-1:0] cmd_delay;
    logic [4:0]       cmd_addr;
    logic [7:0]       cmd_data;
    logic             cmd_read;
    logic             sid_we;
    logic [4:0]       sid_addr;
    logic [7:0]       sid_data;
    logic [7:0]       sid_data_out;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic             busy;
    logic [LW-1:0]    fifo_level;

    sid_write_sequencer #(.DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
        .clk(clk), .reset(reset), .ce_1m(ce_1m), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_delay(cmd_delay),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_read(cmd_read),
        .sid_we(sid_we), .sid_addr(sid_addr), .sid_data(sid_data),
        .sid_data_out(sid_data_out), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Stand-in for the sid8580 read mux.
    function automatic int sid_reg(input int a);
        return (a == 'h1B) ? 'h5A : a;
    endfunction
    assign sid_data_out = 8'(sid_reg(32'(sid_addr)));

    typedef struct {
        int tick;
        int addr;
        int data;
        bit rd;
        bit src_rd;
    } exp_t;

    exp_t exp_q[$];
    int   last_tick = 0;
    int   cyc = 0;
    int   tick_cnt = 0;
    int   we_cnt = 0;
    int   rd_cnt = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input int d, input int a, input int dat, input bit rd, input int ptick);
        exp_t e;
        e.tick   = ((last_tick > ptick) ? last_tick : ptick) + d + 1;
        last_tick = e.tick;
        e.addr   = a;
        e.src_rd = rd;
`ifdef SID_SEQ_READBACK_EN
        e.rd   = rd;
        e.data = rd ? sid_reg(a) : dat;
`else
        e.rd   = 1'b0;
        e.data = dat;
`endif
        exp_q.push_back(e);
    endtask

    task automatic model_clear();
        exp_q.delete();
        last_tick = 0;
    endtask

    // Keep single pushes off the ce edge and the edge before it so the pop never races a tick.
    task automatic wait_safe();
        while ((((cyc + 1) % CE_P) == 0) || (((cyc + 2) % CE_P) == 0)) @(negedge clk);
    endtask

    task automatic push_cmd(input int d, input int a, input int dat, input bit rd);
        bit acc;
        wait_safe();
        cmd_valid = 1'b1;
        cmd_delay = DLY_W'(d);
        cmd_addr  = 5'(a);
        cmd_data  = 8'(dat);
        cmd_read  = rd;
        acc       = cmd_ready;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_read  = 1'b0;
        check("push_ready", 32'(acc), 32'(1));
        if (acc) model_push(d, a, dat, rd, tick_cnt);
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while ((exp_q.size() != 0 || busy) && g < LIMIT) begin
            @(negedge clk);
            g++;
        end
        checks++;
        assert (g < LIMIT) else begin
            failures++;
            $error("FAIL %s_drain observed=%0d pending expected=0 pending", tag, exp_q.size());
        end
    endtask

    // Clock-count and ce_1m tick counter, both sampled on the active edge.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (ce_1m) tick_cnt = tick_cnt + 1;
    end

    initial forever begin
        @(negedge clk);
        ce_1m = ((cyc % CE_P) == (CE_P - 1));
    end

    // Bus monitor: every sid_we / rd_valid pulse must match the head of the expected queue.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset) check("we_in_reset", 32'(sid_we), 32'(0));
        if (sid_we === 1'b1) begin
            we_cnt++;
            checks++;
            assert (exp_q.size() != 0 && !exp_q[0].rd) else begin
                failures++;
                $error("FAIL unexpected_we observed addr=0x%0h data=0x%0h expected no write", sid_addr, sid_data);
            end
            if (exp_q.size() != 0 && !exp_q[0].rd) begin
                e = exp_q.pop_front();
                check("we_tick", 32'(tick_cnt), 32'(e.tick));
                check("we_addr", 32'(sid_addr), 32'(e.addr));
                check("we_data", 32'(sid_data), 32'(e.data));
            end
        end
        if (rd_valid === 1'b1) begin
            rd_cnt++;
`ifdef SID_SEQ_READBACK_EN
            checks++;
            assert (exp_q.size() != 0 && exp_q[0].rd) else begin
                failures++;
                $error("FAIL unexpected_rd observed rd_data=0x%0h expected no read", rd_data);
            end
            if (exp_q.size() != 0 && exp_q[0].rd) begin
                e = exp_q.pop_front();
                check("rd_tick", 32'(tick_cnt), 32'(e.tick));
                check("rd_addr", 32'(sid_addr), 32'(e.addr));
                check("rd_data", 32'(rd_data), 32'(e.data));
            end
`endif
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int we0;
        int rd0;
        int n_acc;
        bit acc;
        bit stalled;
        int fd [DEPTH+2];
        int fa [DEPTH+2];
        int fdat [DEPTH+2];

        reset = 1'b1; flush = 1'b0; cmd_valid = 1'b0;
        cmd_delay = '0; cmd_addr = '0; cmd_data = '0; cmd_read = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_sid_we", 32'(sid_we), 32'(0));
        check("rst_sid_addr", 32'(sid_addr), 32'(0));
        check("rst_sid_data", 32'(sid_data), 32'(0));
        check("rst_rd_valid", 32'(rd_valid), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_level", 32'(fifo_level), 32'(0));
        check("rst_ready", 32'(cmd_ready), 32'(1));

        // Single zero-delay write; busy must drop right after the pulse.
        push_cmd(0, 'h18, 'h0F, 1'b0);
        g = 0;
        while (sid_we !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("t1_we_seen", 32'(sid_we), 32'(1));
        @(negedge clk);
        check("t1_busy_after", 32'(busy), 32'(0));
        drain("t1");

        // Delay 3 then delay 0: fourth tick after pop, then the very next tick.
        we0 = we_cnt;
        push_cmd(3, 'h01, 'h11, 1'b0);
        push_cmd(0, 'h04, 'h21, 1'b0);
        drain("t2");
        check("t2_we_count", 32'(we_cnt - we0), 32'(2));

        // Overfill with cmd_valid held; the first entry is popped into the sequencer immediately.
        for (int i = 0; i < DEPTH + 2; i++) begin
            fd[i]   = (i == 0) ? 20 : int'($urandom_range(0, 3));
            fa[i]   = int'($urandom_range(0, 31));
            fdat[i] = int'($urandom_range(0, 255));
        end
        we0 = we_cnt;
        n_acc = 0; g = 0; stalled = 1'b0;
        wait_safe();
        while (n_acc < DEPTH + 2 && g < LIMIT) begin
            cmd_valid = 1'b1;
            cmd_delay = DLY_W'(fd[n_acc]);
            cmd_addr  = 5'(fa[n_acc]);
            cmd_data  = 8'(fdat[n_acc]);
            acc = cmd_ready;
            if (!acc && !stalled) begin
                stalled = 1'b1;
                check("t3_full_level", 32'(fifo_level), 32'(DEPTH));
                check("t3_accepted_before_full", 32'(n_acc), 32'(DEPTH + 1));
            end
            @(posedge clk);
            @(negedge clk);
            g++;
            if (acc) begin
                model_push(fd[n_acc], fa[n_acc], fdat[n_acc], 1'b0, tick_cnt);
                n_acc++;
            end
        end
        cmd_valid = 1'b0;
        check("t3_stall_seen", 32'(stalled), 32'(1));
        check("t3_all_accepted", 32'(n_acc), 32'(DEPTH + 2));
        drain("t3");
        check("t3_we_count", 32'(we_cnt - we0), 32'(DEPTH + 2));

        // Randomized streams with random idle gaps between pushes.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) begin
                push_cmd(int'($urandom_range(0, 5)), int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 255)), 1'b0);
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
            drain("rand");
        end

        // Flush during the first long wait, with a push offered in the flush cycle.
        for (int k = 0; k < 5; k++) push_cmd(100, 'h08 + k, 'h30 + k, 1'b0);
        repeat (20) @(negedge clk);
        check("t4_busy_pre", 32'(busy), 32'(1));
        check("t4_level_pre", 32'(fifo_level), 32'(4));
        we0 = we_cnt;
        flush = 1'b1;
        cmd_valid = 1'b1; cmd_delay = '0; cmd_addr = 5'h1F; cmd_data = 8'hEE;
        @(negedge clk);
        flush = 1'b0;
        cmd_valid = 1'b0;
        model_clear();
        check("t4_level_post", 32'(fifo_level), 32'(0));
        check("t4_busy_post", 32'(busy), 32'(0));
        repeat (900) @(negedge clk);
        check("t4_no_we_after_flush", 32'(we_cnt - we0), 32'(0));
        push_cmd(2, 'h07, 'h77, 1'b0);
        drain("t4");
        check("t4_we_after", 32'(we_cnt - we0), 32'(1));

        // Reset in the middle of a wait.
        we0 = we_cnt;
        push_cmd(10, 'h05, 'hAA, 1'b0);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        check("t5_in_rst_addr", 32'(sid_addr), 32'(0));
        check("t5_in_rst_level", 32'(fifo_level), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5_sid_addr", 32'(sid_addr), 32'(0));
        check("t5_sid_data", 32'(sid_data), 32'(0));
        check("t5_busy", 32'(busy), 32'(0));
        check("t5_ready", 32'(cmd_ready), 32'(1));
        repeat (150) @(negedge clk);
        check("t5_no_we", 32'(we_cnt - we0), 32'(0));

        // Write then read of a register whose modelled value is 0x5A.
        we0 = we_cnt;
        rd0 = rd_cnt;
        push_cmd(0, 'h12, 'h81, 1'b0);
        push_cmd(0, 'h1B, 'h00, 1'b1);
        drain("t6");
`ifdef SID_SEQ_READBACK_EN
        check("t6_we_count", 32'(we_cnt - we0), 32'(1));
        check("t6_rd_count", 32'(rd_cnt - rd0), 32'(1));
        check("t6_rd_data", 32'(rd_data), 32'('h5A));
        check("t6_sid_data_kept", 32'(sid_data), 32'('h81));
`else
        check("t6_we_count", 32'(we_cnt - we0), 32'(2));
        check("t6_rd_count", 32'(rd_cnt), 32'(0));
        check("t6_rd_data", 32'(rd_data), 32'(0));
        check("t6_last_addr", 32'(sid_addr), 32'('h1B));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
